// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - fetch-unit signal bundle: control inputs, memory port and fetched-word outputs
interface instruction_fetch_if #(
    parameter int D = 12
);
    logic         start;
    logic         stall;
    logic         branchTaken;
    logic [D-1:0] branchTarget;
    logic [8:0]   machineCode;
    logic [D-1:0] programCounter;
    logic [8:0]   instruction;
    logic [D-1:0] instrAddr;
    logic         instrValid;
    logic         done;

    modport master (
        input  start, stall, branchTaken, branchTarget, machineCode,
        output programCounter, instruction, instrAddr, instrValid, done
    );

    modport slave (
        output start, stall, branchTaken, branchTarget, machineCode,
        input  programCounter, instruction, instrAddr, instrValid, done
    );
endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - IDLE/RUN/HALTED fetch unit; BRANCH_RELATIVE_EN makes branches instrAddr-relative
module instruction_fetch #(
    parameter int D = 12
) (
    input  logic               clk,
    input  logic               reset,
    instruction_fetch_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;

    localparam logic [8:0] HALT_WORD = 9'h1FF;

    state_t       state, state_nxt;
    logic [D-1:0] pc_q, pc_nxt;
    logic [8:0]   instr_q, instr_nxt;
    logic [D-1:0] addr_q, addr_nxt;
    logic         valid_q, valid_nxt;
    logic         done_q, done_nxt;
    logic [D-1:0] target;

`ifdef BRANCH_RELATIVE_EN
    // Offset is two's complement, so a plain D-bit add gives the wrapped result.
    assign target = addr_q + bus.branchTarget;
`else
    assign target = bus.branchTarget;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_q    <= pc_nxt;
            instr_q <= instr_nxt;
            addr_q  <= addr_nxt;
            valid_q <= valid_nxt;
            done_q  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        instr_nxt = instr_q;
        addr_nxt  = addr_q;
        valid_nxt = valid_q;
        case (state)
            IDLE, HALTED: begin
                if (bus.start) begin
                    state_nxt = RUN;
                    pc_nxt    = '0;
                    valid_nxt = 1'b0;
                end
            end
            RUN: begin
                if (bus.branchTaken) begin
                    pc_nxt    = target;
                    valid_nxt = 1'b0;
                end else if (bus.stall) begin
                    state_nxt = RUN;
                end else if (bus.machineCode == HALT_WORD) begin
                    state_nxt = HALTED;
                    valid_nxt = 1'b0;
                end else begin
                    instr_nxt = bus.machineCode;
                    addr_nxt  = pc_q;
                    valid_nxt = 1'b1;
                    pc_nxt    = pc_q + D'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        done_nxt = (state_nxt == HALTED);
    end

    assign bus.programCounter = pc_q;
    assign bus.instruction    = instr_q;
    assign bus.instrAddr      = addr_q;
    assign bus.instrValid     = valid_q;
    assign bus.done           = done_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - table, directed and randomized checks of instruction_fetch against a reference model
module tb_instruction_fetch;
    localparam int D = 12;
    localparam int N = 1 << D;

    logic clk = 1'b0;
    logic reset = 1'b1;

    instruction_fetch_if #(.D(D)) bus();
    instruction_fetch #(.D(D)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    logic [8:0] mem [N];
    assign bus.machineCode = mem[bus.programCounter];

    int n_checks = 0;
    int n_fail   = 0;

    int           m_mode;  // 0 idle, 1 running, 2 halted
    logic [D-1:0] m_pc, m_addr;
    logic [8:0]   m_instr;
    logic         m_valid, m_done;

    typedef struct {
        logic         st, sl, br;
        logic [D-1:0] tg;
        logic [D-1:0] pc;
        logic [8:0]   ins;
        logic [D-1:0] adr;
        logic         vld, dn;
    } vec_t;
    vec_t tbl [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = '0; m_addr = '0; m_instr = '0; m_valid = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic sl, input logic br, input logic [D-1:0] tg);
        if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = '0; m_valid = 1'b0; m_done = 1'b0;
            end
        end else if (br) begin
`ifdef BRANCH_RELATIVE_EN
            m_pc = D'((int'(m_addr) + int'(tg)) % N);
`else
            m_pc = tg;
`endif
            m_valid = 1'b0;
        end else if (!sl) begin
            if (mem[m_pc] == 9'h1FF) begin
                m_mode = 2; m_valid = 1'b0; m_done = 1'b1;
            end else begin
                m_instr = mem[m_pc];
                m_addr  = m_pc;
                m_valid = 1'b1;
                m_pc    = D'((int'(m_pc) + 1) % N);
            end
        end
    endtask

    task automatic step(input logic st, input logic sl, input logic br, input logic [D-1:0] tg);
        bus.start = st; bus.stall = sl; bus.branchTaken = br; bus.branchTarget = tg;
        model_step(st, sl, br, tg);
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_pc"},    32'(bus.programCounter), 32'(m_pc));
        check({tag, "_instr"}, 32'(bus.instruction),    32'(m_instr));
        check({tag, "_addr"},  32'(bus.instrAddr),      32'(m_addr));
        check({tag, "_valid"}, 32'(bus.instrValid),     32'(m_valid));
        check({tag, "_done"},  32'(bus.done),           32'(m_done));
    endtask

    task automatic check_out(input string tag, input logic [D-1:0] pc, input logic [8:0] ins,
                             input logic [D-1:0] adr, input logic vld, input logic dn);
        check({tag, "_pc"},    32'(bus.programCounter), 32'(pc));
        check({tag, "_instr"}, 32'(bus.instruction),    32'(ins));
        check({tag, "_addr"},  32'(bus.instrAddr),      32'(adr));
        check({tag, "_valid"}, 32'(bus.instrValid),     32'(vld));
        check({tag, "_done"},  32'(bus.done),           32'(dn));
    endtask

    task automatic do_reset();
        bus.start = 1'b0; bus.stall = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = '0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [D-1:0] tgt_for(input logic [D-1:0] dest);
`ifdef BRANCH_RELATIVE_EN
        return dest - m_addr;
`else
        return dest;
`endif
    endfunction

    initial begin
        bus.start = 1'b0; bus.stall = 1'b0; bus.branchTaken = 1'b0; bus.branchTarget = '0;
        for (int i = 0; i < N; i++) mem[i] = 9'($urandom_range(0, 9'h1FE));
        mem[0] = 9'h0FE; mem[1] = 9'h0CC; mem[2] = 9'h1FF;
        model_reset();

        #12;
        check_out("reset", '0, '0, '0, 1'b0, 1'b0);
        reset = 1'b0;

        //         st sl br  tg       pc       ins      adr     vld dn
        tbl[0] = '{1, 0, 0, 12'h000, 12'h000, 9'h000, 12'h000, 0, 0};
        tbl[1] = '{0, 0, 0, 12'h000, 12'h001, 9'h0FE, 12'h000, 1, 0};
        tbl[2] = '{0, 0, 0, 12'h000, 12'h002, 9'h0CC, 12'h001, 1, 0};
        tbl[3] = '{0, 0, 0, 12'h000, 12'h002, 9'h0CC, 12'h001, 0, 1};
        tbl[4] = '{0, 0, 1, 12'h040, 12'h002, 9'h0CC, 12'h001, 0, 1};
        tbl[5] = '{1, 0, 0, 12'h000, 12'h000, 9'h0CC, 12'h001, 0, 0};
        for (int i = 0; i < 6; i++) begin
            step(tbl[i].st, tbl[i].sl, tbl[i].br, tbl[i].tg);
            check_out($sformatf("tbl%0d", i), tbl[i].pc, tbl[i].ins, tbl[i].adr, tbl[i].vld, tbl[i].dn);
        end

        // stall, branch and wrap sequences on a halt-free program
        mem[2] = 9'h033;
        do_reset();
        step(1, 0, 0, '0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, '0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, '0);
            check_out("stall", 12'd5, mem[4], 12'd4, 1'b1, 1'b0);
        end
        step(0, 0, 0, '0);
        check_out("resume", 12'd6, mem[5], 12'd5, 1'b1, 1'b0);
        step(0, 0, 0, '0);
        step(0, 0, 1, tgt_for(12'h040));
        check_out("branch", 12'h040, mem[6], 12'd6, 1'b0, 1'b0);
        step(0, 0, 0, '0);
        check_out("br_fetch", 12'h041, mem[12'h040], 12'h040, 1'b1, 1'b0);
        step(0, 1, 1, tgt_for(12'hFFE));
        check_out("br_stall", 12'hFFE, mem[12'h040], 12'h040, 1'b0, 1'b0);
        step(0, 0, 0, '0);
        check_out("wrap0", 12'hFFF, mem[12'hFFE], 12'hFFE, 1'b1, 1'b0);
        step(0, 0, 0, '0);
        check_out("wrap1", 12'h000, mem[12'hFFF], 12'hFFF, 1'b1, 1'b0);
        step(0, 0, 0, '0);
        check_out("wrap2", 12'h001, mem[0], 12'h000, 1'b1, 1'b0);

        // asynchronous reset between clock edges
        #3;
        reset = 1'b1;
        #1;
        check_out("async_rst", '0, '0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        model_reset();
        step(0, 0, 0, '0);
        step(0, 0, 1, 12'h123);
        check_out("post_rst_idle", '0, '0, '0, 1'b0, 1'b0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);
        check_out("post_rst_run", 12'd1, mem[0], 12'd0, 1'b1, 1'b0);

        // randomized run against the reference model
        for (int i = 0; i < N; i++)
            mem[i] = ($urandom_range(0, 19) == 0) ? 9'h1FF : 9'($urandom_range(0, 9'h1FE));
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) == 0), D'($urandom));
            check_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
